pipelined_datapath: RTL and testbench
=====================================

Name: pipelined_datapath

Overview:
- Two-stage (EX, MEM/WB) successor to the single-cycle datapath, parametrised in data width and register count.
- Stage 1 reads the register file and runs the ALU. Stage 2 performs an optional memory access over a req/ack handshake, then writes back.
- A valid/ready issue handshake stalls upstream while stage 2 waits on memory.
- Sits between the decoder/controller (supplies instr, imm and control) and the data memory port.

Parameters:
- XLEN, 32: datapath width (≥8).
- NREGS, 32: architectural registers. Power of 2, ≤32. Index = low $clog2(NREGS) bits of the instr fields.
- ALU_W, 3: alu_ctrl width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue request.
- in_ready  out  1  issue accepted when in_valid && in_ready.
- instr  in  32  RV32 encoding. rs1=[19:15], rs2=[24:20], rd=[11:7].
- imm  in  XLEN  immediate, already extended.
- we  in  1  register write enable.
- alu_src  in  1  1: B=imm, 0: B=rs2 value.
- result_src  in  1  1: writeback ALU result, 0: writeback mem_rd (load).
- mem_write  in  1  store.
- alu_ctrl  in  ALU_W  ALU operation.
- zero  out  1  stage-1 ALU result == 0, combinational.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  store qualifier.
- mem_addr  out  XLEN  ALU result held in stage 2.
- mem_wd  out  XLEN  rs2 value captured at issue.
- mem_ack  in  1  request complete; load data valid.
- mem_rd  in  XLEN  load data.
- retire_valid  out  1  stage-2 completion pulse.
- retire_rd  out  5  destination index (0 when no write).
- retire_wd  out  XLEN  writeback value.

Behaviour:
- ALU ops: 000 add, 001 sub, 010 and, 011 or, 101 signed slt (result 1/0). Other codes give 0. Arithmetic is mod 2^XLEN.
- Register file: 2 async read ports, 1 sync write port. x0 reads 0 and writes to it are dropped. Contents are not cleared by rst.
- Stage 1 (combinational): operand read, forwarding, ALU. On issue, stage-2 register captures alu_out, rs2 value, rd, we, result_src, mem_write, and sets s2_valid.
- s2 is a memory op if result_src==0 or mem_write==1.
- s2_done:
  - s2_valid && !memop, or
  - s2_valid && memop && mem_ack.
- mem_req = s2_valid && memop; mem_we = mem_req && mem_write. Both held stable until the ack cycle.
- mem_ack is ignored while mem_req=0. Zero-wait (ack in the first request cycle) is legal.
- Stage-2 latency is 1 cycle for ALU ops, 1+N cycles for memory ops with N wait cycles.
- On the s2_done cycle:
  - If we && rd!=0 && !mem_write, rf[rd] is written at the edge with the result_src-selected value.
  - retire_valid=1; retire_wd = the written value, or mem_wd for stores.
  - s2_valid clears unless a new issue occurs in the same cycle.
- in_ready = !s2_valid || s2_done, giving one instruction per cycle for ALU ops.
- Forwarding: if s2_done, s2 writes, rd!=0 and rd matches rs1 or rs2, stage 1 uses the writeback value. Both operands may forward at once.
- Load-use hazard resolves by stalling, because in_ready=0 until the ack cycle.
- rst:
  - s2_valid=0; mem_req, mem_we, retire_valid=0; mem_addr, mem_wd, retire_rd, retire_wd=0. in_ready=1 after the reset edge.
  - An in-flight access is abandoned. Its ack, if it arrives later, is ignored. No writeback occurs.
  - An issue in the reset cycle is discarded.

Optional Feature:
- Macro PIPE_FWD_EN.
- Defined: forwarding as above, throughput 1/cycle.
- Undefined: no forwarding; in_ready = !s2_valid, so each issue waits for the previous retire. Throughput 1 per 2 cycles for ALU ops. Architectural results are identical.

Test Plan:
- rf x1=5, x2=7. Issue add x3,x1,x2 (alu_src=0, we=1, result_src=1) → next cycle retire_valid=1, retire_rd=3, retire_wd=12. No mem_req.
- Back-to-back addi x4,x3,1 then addi x5,x4,1 from x3=12, with PIPE_FWD_EN → retires 13 then 14 in consecutive cycles, in_ready held 1. Without the macro, the two issues are 2 cycles apart and give the same values.
- Load x6 ← [x1+4], mem_ack after 3 wait cycles, mem_rd=0xDEADBEEF:
  - mem_req=1 for 4 cycles with mem_addr=9 stable; in_ready=0 during the wait.
  - The next add x7,x6,x0 issued on the ack cycle produces 0xDEADBEEF.
- Store [x2+0] ← x1 with zero-wait ack → mem_req=1, mem_we=1, mem_addr=7, mem_wd=5 for one cycle. No rf write.
- sub x8,x1,x1 → zero=1 in its issue cycle. slt x9,x1,x2 → 1. Write to x0 → x0 still reads 0.
- Load pending with no ack, rst asserted 1 cycle → mem_req=0 after the edge, in_ready=1, no retire. A stray mem_ack afterwards has no effect.

Source files
------------

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage (EX, MEM/WB) integer datapath.
//
// Stage 1 (combinational): register-file read, optional forwarding from stage 2,
// and the ALU. An issue (in_valid && in_ready) loads the stage-2 register.
// Stage 2: an optional data-memory access over a req/ack handshake, then writeback.
//
// Configuration macro: PIPE_FWD_EN
//   defined   - stage 2 forwards its writeback value into stage 1; in_ready also
//               rises on the stage-2 completion cycle (one ALU op per cycle).
//   undefined - no forwarding; in_ready = !s2_valid (one ALU op per two cycles).
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid / in_ready       issue handshake
//   instr, imm                instruction (rs1 [19:15], rs2 [24:20], rd [11:7]), immediate
//   we, alu_src, result_src,  control from the decoder
//   mem_write, alu_ctrl
//   zero                      stage-1 ALU result is zero
//   mem_req, mem_we,          data-memory request side (held until ack)
//   mem_addr, mem_wd
//   mem_ack, mem_rd           data-memory response side
//   retire_valid, retire_rd,  stage-2 completion pulse, destination, written value
//   retire_wd
module pipelined_datapath #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  imm,
  input  logic             we,
  input  logic             alu_src,
  input  logic             result_src,
  input  logic             mem_write,
  input  logic [ALU_W-1:0] alu_ctrl,
  output logic             zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wd,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rd,
  output logic             retire_valid,
  output logic [4:0]       retire_rd,
  output logic [XLEN-1:0]  retire_wd
);

  localparam int unsigned IW = $clog2(NREGS);

  // Register file: reset-less storage, x0 masked on read and never written.
  logic [XLEN-1:0] rf_q [NREGS];

  // Stage-2 state.
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_alu_q, s2_alu_d;
  logic [XLEN-1:0] s2_rs2_q, s2_rs2_d;
  logic [IW-1:0]   s2_rd_q, s2_rd_d;
  logic            s2_we_q, s2_we_d;
  logic            s2_res_src_q, s2_res_src_d;
  logic            s2_mem_write_q, s2_mem_write_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;

  // Stage-1 signals.
  logic [IW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rf_rs1, rf_rs2;
  logic [XLEN-1:0] op_a, rs2_val, op_b;
  logic [XLEN-1:0] alu_out;
  logic            issue;

  // Stage-2 combinational signals.
  logic            s2_done;
  logic            rf_we;
  logic [XLEN-1:0] wb_data;

  // Only the register-index fields of instr are decoded here.
  logic unused_instr;
  assign unused_instr = ^instr;

  assign rs1_idx = instr[15 +: IW];
  assign rs2_idx = instr[20 +: IW];
  assign rd_idx  = instr[7 +: IW];

  assign rf_rs1 = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
  assign rf_rs2 = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

  // Stage 2 completes when it holds a non-memory op, or the memory acks.
  // Reset suppresses completion so an abandoned access never writes back.
  assign s2_done = s2_valid_q && !rst && (!mem_req_q || mem_ack);
  assign wb_data = s2_res_src_q ? s2_alu_q : mem_rd;
  assign rf_we   = s2_done && s2_we_q && !s2_mem_write_q && (s2_rd_q != '0);

`ifdef PIPE_FWD_EN
  always_comb begin
    op_a    = rf_rs1;
    rs2_val = rf_rs2;
    if (rf_we && (s2_rd_q == rs1_idx)) op_a    = wb_data;
    if (rf_we && (s2_rd_q == rs2_idx)) rs2_val = wb_data;
  end
  assign in_ready = !s2_valid_q || s2_done;
`else
  assign op_a     = rf_rs1;
  assign rs2_val  = rf_rs2;
  assign in_ready = !s2_valid_q;
`endif

  assign op_b  = alu_src ? imm : rs2_val;
  assign issue = in_valid && in_ready;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_W'(0): alu_out = op_a + op_b;
      ALU_W'(1): alu_out = op_a - op_b;
      ALU_W'(2): alu_out = op_a & op_b;
      ALU_W'(3): alu_out = op_a | op_b;
      ALU_W'(5): alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default:   alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  // Stage-2 next state: a new issue overrides completion of the current op.
  always_comb begin
    s2_valid_d     = s2_valid_q;
    s2_alu_d       = s2_alu_q;
    s2_rs2_d       = s2_rs2_q;
    s2_rd_d        = s2_rd_q;
    s2_we_d        = s2_we_q;
    s2_res_src_d   = s2_res_src_q;
    s2_mem_write_d = s2_mem_write_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    if (issue) begin
      s2_valid_d     = 1'b1;
      s2_alu_d       = alu_out;
      s2_rs2_d       = rs2_val;
      s2_rd_d        = rd_idx;
      s2_we_d        = we;
      s2_res_src_d   = result_src;
      s2_mem_write_d = mem_write;
      mem_req_d      = !result_src || mem_write;
      mem_we_d       = mem_write;
    end else if (s2_done) begin
      s2_valid_d = 1'b0;
      mem_req_d  = 1'b0;
      mem_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q     <= 1'b0;
      s2_alu_q       <= '0;
      s2_rs2_q       <= '0;
      s2_rd_q        <= '0;
      s2_we_q        <= 1'b0;
      s2_res_src_q   <= 1'b0;
      s2_mem_write_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
    end else begin
      s2_valid_q     <= s2_valid_d;
      s2_alu_q       <= s2_alu_d;
      s2_rs2_q       <= s2_rs2_d;
      s2_rd_q        <= s2_rd_d;
      s2_we_q        <= s2_we_d;
      s2_res_src_q   <= s2_res_src_d;
      s2_mem_write_q <= s2_mem_write_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) rf_q[s2_rd_q] <= wb_data;
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = s2_alu_q;
  assign mem_wd   = s2_rs2_q;

  // Retire outputs are zero outside the completion cycle.
  assign retire_valid = s2_done;
  assign retire_rd    = rf_we ? 5'(s2_rd_q) : 5'd0;
  assign retire_wd    = !s2_done      ? '0 :
                        s2_mem_write_q ? s2_rs2_q : wb_data;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath with a retire scoreboard.
module tb_pipelined_datapath;

`ifdef PIPE_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] imm;
  logic        we;
  logic        alu_src;
  logic        result_src;
  logic        mem_write;
  logic [2:0]  alu_ctrl;
  logic        zero;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_ack;
  logic [31:0] mem_rd;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_wd;

  pipelined_datapath #(
    .XLEN (32),
    .NREGS(32),
    .ALU_W(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .imm         (imm),
    .we          (we),
    .alu_src     (alu_src),
    .result_src  (result_src),
    .mem_write   (mem_write),
    .alu_ctrl    (alu_ctrl),
    .zero        (zero),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_ack     (mem_ack),
    .mem_rd      (mem_rd),
    .retire_valid(retire_valid),
    .retire_rd   (retire_rd),
    .retire_wd   (retire_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    logic [4:0] d, s1, s2;
    d  = 5'(rd);
    s1 = 5'(rs1);
    s2 = 5'(rs2);
    return {7'b0, s2, s1, 3'b0, d, 7'b0110011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and holds it until accepted. Pushes the expected
  // retire when push is set; reports stall cycles and zero in the accept cycle.
  task automatic issue(input logic [31:0] ins, input logic [31:0] im, input logic w,
                       input logic asrc, input logic rsrc, input logic mw,
                       input logic [2:0] ctl, input bit push, input int exp_rd,
                       input logic [31:0] exp_wd, output int waits, output logic z);
    logic rdy;
    instr      = ins;
    imm        = im;
    we         = w;
    alu_src    = asrc;
    result_src = rsrc;
    mem_write  = mw;
    alu_ctrl   = ctl;
    in_valid   = 1'b1;
    waits      = 0;
    #1;
    rdy = in_ready;
    z   = zero;
    while (!rdy && waits < 20) begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      waits++;
      #1;
      rdy = in_ready;
      z   = zero;
    end
    if (!rdy) check("issue_timeout", 64'(rdy), 64'd1);
    if (rdy && push) exp_q.push_back('{rd: 5'(exp_rd), wd: exp_wd});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  int   w;
  logic z;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    instr      = '0;
    imm        = '0;
    we         = 1'b0;
    alu_src    = 1'b0;
    result_src = 1'b1;
    mem_write  = 1'b0;
    alu_ctrl   = '0;
    mem_ack    = 1'b0;
    mem_rd     = '0;
    n_vec      = 0;
    n_err      = 0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && retire_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", {27'd0, retire_rd, retire_wd}, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("retire_rd", 64'(retire_rd), 64'(e.rd));
            check("retire_wd", 64'(retire_wd), 64'(e.wd));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_retire_valid", 64'(retire_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wd", 64'(mem_wd), 64'd0);
    check("rst_retire_rd", 64'(retire_rd), 64'd0);
    check("rst_retire_wd", 64'(retire_wd), 64'd0);

    // Seed x1=5, x2=7, then add x3,x1,x2 = 12.
    issue(mk(1, 0, 0), 32'd5, 1, 1, 1, 0, 3'b000, 1, 1, 32'd5, w, z);
    issue(mk(2, 0, 0), 32'd7, 1, 1, 1, 0, 3'b000, 1, 2, 32'd7, w, z);
    issue(mk(3, 1, 2), 32'd0, 1, 0, 1, 0, 3'b000, 1, 3, 32'd12, w, z);
    check("add_zero", 64'(z), 64'd0);
    #1;
    check("add_retire_now", 64'(retire_valid), 64'd1);
    check("add_no_mem_req", 64'(mem_req), 64'd0);

    // Dependent addi chain.
    issue(mk(4, 3, 0), 32'd1, 1, 1, 1, 0, 3'b000, 1, 4, 32'd13, w, z);
    issue(mk(5, 4, 0), 32'd1, 1, 1, 1, 0, 3'b000, 1, 5, 32'd14, w, z);
    check("chain_stall_cycles", 64'(w), (FWD != 0) ? 64'd0 : 64'd1);

    // Load x6 <- [x1+4] with three wait cycles, then dependent add on ack cycle.
    issue(mk(6, 1, 0), 32'd4, 1, 1, 0, 0, 3'b000, 1, 6, 32'hDEADBEEF, w, z);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_wait_req", 64'(mem_req), 64'd1);
      check("ld_wait_addr", 64'(mem_addr), 64'd9);
      check("ld_wait_we", 64'(mem_we), 64'd0);
      check("ld_wait_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    mem_ack = 1'b1;
    mem_rd  = 32'hDEADBEEF;
    #1;
    check("ld_ack_req", 64'(mem_req), 64'd1);
    check("ld_ack_addr", 64'(mem_addr), 64'd9);
    issue(mk(7, 6, 0), 32'd0, 1, 0, 1, 0, 3'b000, 1, 7, 32'hDEADBEEF, w, z);
    check("load_use_stall", 64'(w), (FWD != 0) ? 64'd0 : 64'd1);
    mem_rd = 32'h0;

    // Store [x2+0] <- x1, zero-wait ack; rd field nonzero must not write x3.
    issue(mk(3, 2, 1), 32'd0, 0, 1, 1, 1, 3'b000, 1, 0, 32'd5, w, z);
    mem_ack = 1'b1;
    #1;
    check("st_req", 64'(mem_req), 64'd1);
    check("st_we", 64'(mem_we), 64'd1);
    check("st_addr", 64'(mem_addr), 64'd7);
    check("st_wd", 64'(mem_wd), 64'd5);
    step();
    mem_ack = 1'b0;
    #1;
    check("st_req_drop", 64'(mem_req), 64'd0);
    issue(mk(18, 3, 0), 32'd0, 1, 0, 1, 0, 3'b000, 1, 18, 32'd12, w, z);

    // ALU operations.
    issue(mk(8, 1, 1), 32'd0, 1, 0, 1, 0, 3'b001, 1, 8, 32'd0, w, z);
    check("sub_zero", 64'(z), 64'd1);
    issue(mk(9, 1, 2), 32'd0, 1, 0, 1, 0, 3'b101, 1, 9, 32'd1, w, z);
    issue(mk(13, 0, 0), 32'hFFFFFFFF, 1, 1, 1, 0, 3'b000, 1, 13, 32'hFFFFFFFF, w, z);
    issue(mk(14, 13, 1), 32'd0, 1, 0, 1, 0, 3'b101, 1, 14, 32'd1, w, z);
    issue(mk(19, 1, 13), 32'd0, 1, 0, 1, 0, 3'b101, 1, 19, 32'd0, w, z);
    issue(mk(15, 1, 2), 32'd0, 1, 0, 1, 0, 3'b010, 1, 15, 32'd5, w, z);
    issue(mk(16, 1, 2), 32'd0, 1, 0, 1, 0, 3'b011, 1, 16, 32'd7, w, z);
    issue(mk(20, 1, 2), 32'd0, 1, 0, 1, 0, 3'b111, 1, 20, 32'd0, w, z);
    issue(mk(21, 1, 2), 32'd0, 1, 0, 1, 0, 3'b001, 1, 21, 32'hFFFFFFFE, w, z);

    // Write to x0 is dropped; x0 still reads zero.
    issue(mk(0, 1, 0), 32'd9, 1, 1, 1, 0, 3'b000, 1, 0, 32'd14, w, z);
    issue(mk(17, 0, 0), 32'd0, 1, 0, 1, 0, 3'b000, 1, 17, 32'd0, w, z);
    check("x0_zero", 64'(z), 64'd1);

    // Reset with a load pending: no writeback, stray ack ignored.
    issue(mk(10, 0, 0), 32'd55, 1, 1, 1, 0, 3'b000, 1, 10, 32'd55, w, z);
    issue(mk(10, 1, 0), 32'd0, 1, 1, 0, 0, 3'b000, 0, 0, 32'd0, w, z);
    #1;
    check("rs_pending_req", 64'(mem_req), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    instr    = mk(11, 0, 0);
    imm      = 32'd99;
    we       = 1'b1;
    alu_src  = 1'b1;
    result_src = 1'b1;
    mem_write  = 1'b0;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rs_mem_req", 64'(mem_req), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    check("rs_retire", 64'(retire_valid), 64'd0);
    check("rs_mem_addr", 64'(mem_addr), 64'd0);
    mem_ack = 1'b1;
    mem_rd  = 32'h12345678;
    #1;
    check("stray_ack_retire", 64'(retire_valid), 64'd0);
    check("stray_ack_req", 64'(mem_req), 64'd0);
    step();
    mem_ack = 1'b0;
    issue(mk(11, 10, 0), 32'd0, 1, 0, 1, 0, 3'b000, 1, 11, 32'd55, w, z);

    repeat (4) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
